// File: rtl/obuf_drain_reader_pkg.sv
// Shared definitions for the output-buffer drain reader: FSM encodings and FIFO sizing.
package obuf_drain_reader_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_READ  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Pointer width of the skid FIFO; its occupancy counter is one bit wider.
   function automatic int fifo_ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/obuf_drain_reader_if.sv
// Command, output-buffer read port and downstream stream signals of the drain reader.
interface obuf_drain_reader_if #(
   parameter int MEM_ADDR_WIDTH = 11,
   parameter int MEM_DATA_WIDTH = 64,
   parameter int LEN_W          = 12
);
   logic                      start;
   logic [MEM_ADDR_WIDTH-1:0] base_addr;
   logic [LEN_W-1:0]          num_words;
   logic                      busy;
   logic                      done;
   logic                      mem_read_req;
   logic [MEM_ADDR_WIDTH-1:0] mem_read_addr;
   logic [MEM_DATA_WIDTH-1:0] mem_read_data;
   logic                      m_valid;
   logic [MEM_DATA_WIDTH-1:0] m_data;
   logic                      m_last;
   logic                      m_ready;

   modport slave (
      input  start, base_addr, num_words, mem_read_data, m_ready,
      output busy, done, mem_read_req, mem_read_addr, m_valid, m_data, m_last
   );

   modport master (
      output start, base_addr, num_words, mem_read_data, m_ready,
      input  busy, done, mem_read_req, mem_read_addr, m_valid, m_data, m_last
   );
endinterface

// File: rtl/obuf_rd_fifo.sv
// Small synchronous show-ahead FIFO that absorbs unstallable output-buffer read data.
module obuf_rd_fifo
   import obuf_drain_reader_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_push,
   input  logic [WIDTH-1:0]                  i_push_data,
   input  logic                              i_pop,
   output logic [WIDTH-1:0]                  o_head,
   output logic                              o_empty,
   output logic                              o_full,
   output logic [fifo_ptr_w(DEPTH):0]        o_count
);
   localparam int          PW       = fifo_ptr_w(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_do_pop;

   assign w_do_pop = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_count = r_count;

endmodule

// File: rtl/obuf_drain_reader.sv
// Streams a contiguous output-buffer range to the DRAM write path, credit-throttling reads into a skid FIFO.
module obuf_drain_reader
   import obuf_drain_reader_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 11,
   parameter int MEM_DATA_WIDTH = 64,
   parameter int LEN_W          = 12,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic               clk,
   input  logic               reset,
   obuf_drain_reader_if.slave bus
);
   localparam int               PW      = fifo_ptr_w(FIFO_DEPTH);
   localparam logic [PW:0]      CREDITS = FIFO_DEPTH[PW:0];
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t                    r_state;
   logic [MEM_ADDR_WIDTH-1:0] r_addr;
   logic [LEN_W-1:0]          r_req_left;
   logic [LEN_W-1:0]          r_ack_left;
   logic                      r_inflight;

   logic                      w_issue;
   logic                      w_xfer;
   logic                      w_fifo_empty;
   logic                      w_fifo_full;
   logic [PW:0]               w_fifo_count;
   logic [MEM_DATA_WIDTH-1:0] w_fifo_head;

   // A read returns next cycle whether or not downstream is ready, so it needs a free slot now.
   assign w_issue = (r_state == ST_READ) && (r_req_left != '0)
                    && ((w_fifo_count + {{PW{1'b0}}, r_inflight}) < CREDITS);
   assign w_xfer  = !w_fifo_empty && bus.m_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_req_left <= '0;
         r_ack_left <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_addr     <= r_addr + 1'b1;
            r_req_left <= r_req_left - 1'b1;
         end
         if (w_xfer) r_ack_left <= r_ack_left - 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_addr     <= bus.base_addr;
                  r_req_left <= bus.num_words;
                  r_ack_left <= bus.num_words;
                  r_state    <= (bus.num_words == '0) ? ST_DONE : ST_READ;
               end
            end
            ST_READ: begin
               if (w_issue && (r_req_left == LEN_ONE)) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (w_xfer && (r_ack_left == LEN_ONE)) r_state <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   obuf_rd_fifo #(
      .WIDTH (MEM_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (r_inflight),
      .i_push_data (bus.mem_read_data),
      .i_pop       (w_xfer),
      .o_head      (w_fifo_head),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full),
      .o_count     (w_fifo_count)
   );

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(r_inflight && w_fifo_full && !w_xfer));

   assign bus.busy          = (r_state != ST_IDLE);
   assign bus.done          = (r_state == ST_DONE);
   assign bus.mem_read_req  = w_issue;
   assign bus.mem_read_addr = r_addr;
   assign bus.m_valid       = !w_fifo_empty;
   assign bus.m_data        = w_fifo_empty ? '0 : w_fifo_head;
   assign bus.m_last        = !w_fifo_empty && (r_ack_left == LEN_ONE);

endmodule
